// File: rtl/kpfifo_pkg.sv
// Shared key codes, FSM states, error codes and entry-accumulator commands
// for the keypad-to-FIFO command controller.
package kpfifo_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_PUSH      = 4'hA;
    localparam logic [3:0] KEY_POP       = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [3:0] KEY_FLUSH     = 4'hD;
    localparam logic [3:0] KEY_BS        = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP_RD,
        ST_POP_CAP,
        ST_FL_RD,
        ST_FL_CAP
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_PUSH_FULL  = 2'b01,
        ERR_POP_EMPTY  = 2'b10,
        ERR_PUSH_NODIG = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        ECMD_NONE  = 3'b000,
        ECMD_DIGIT = 3'b001,
        ECMD_BS    = 3'b010,
        ECMD_CLR   = 3'b100
    } entry_cmd_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/kpfifo_entry.sv
// Packed-BCD digit accumulator: shift-in, backspace, clear, saturating count.
module kpfifo_entry
    import kpfifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W / 4 + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  entry_cmd_e        cmd,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] entry,
    output logic [CNT_W-1:0]  digit_cnt
);

    localparam int NIB = DATA_W / 4;

    logic [DATA_W-1:0] entry_d, entry_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        case (cmd)
            ECMD_DIGIT: begin
                // a full entry drops its MSN on shift; count saturates at NIB
                entry_d = (entry_q << 4) | DATA_W'(digit);
                if (cnt_q < CNT_W'(NIB)) cnt_d = cnt_q + CNT_W'(1);
            end
            ECMD_BS: begin
                entry_d = entry_q >> 4;
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            ECMD_CLR: begin
                entry_d = '0;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign entry     = entry_q;
    assign digit_cnt = cnt_q;

endmodule

// File: rtl/keypad_fifo_ctrl.sv
// Keypad command controller driving a synchronous FIFO (push/pop/clear/flush).
// Optional KPFIFO_AUTOPUSH_EN: entry auto-pushes when it reaches NIB digits.
module keypad_fifo_ctrl
    import kpfifo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     key_value,
    input  logic                           key_pressed,
    input  logic                           fifo_full,
    input  logic                           fifo_empty,
    input  logic [DATA_W-1:0]              fifo_rd_data,
    output logic                           fifo_wr_en,
    output logic [DATA_W-1:0]              fifo_wr_data,
    output logic                           fifo_rd_en,
    output logic [DATA_W-1:0]              entry,
    output logic [$clog2(DATA_W/4+1)-1:0]  digit_cnt,
    output logic [DATA_W-1:0]              last_pop,
    output logic                           pop_valid,
    output logic                           busy,
    output logic                           err,
    output logic [1:0]                     err_code
);

    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = $clog2(NIB + 1);

    state_e            state_d, state_q;
    entry_cmd_e        ecmd;
    logic              err_d, err_q;
    err_code_e         err_code_d, err_code_q;
    logic [DATA_W-1:0] last_pop_d, last_pop_q;
`ifdef KPFIFO_AUTOPUSH_EN
    logic              ap_pend_d, ap_pend_q;
    logic              lock_d, lock_q;
`endif

    kpfifo_entry #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_entry (
        .clk       (clk),
        .reset     (reset),
        .cmd       (ecmd),
        .digit     (key_value),
        .entry     (entry),
        .digit_cnt (digit_cnt)
    );

    always_comb begin
        state_d    = state_q;
        ecmd       = ECMD_NONE;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        last_pop_d = last_pop_q;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        pop_valid  = 1'b0;
`ifdef KPFIFO_AUTOPUSH_EN
        ap_pend_d  = 1'b0;
        lock_d     = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef KPFIFO_AUTOPUSH_EN
                // the scheduled push owns this cycle; any key here is dropped
                if (ap_pend_q) begin
                    if (fifo_full) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PUSH_FULL;
                        lock_d     = 1'b1;
                    end else begin
                        state_d = ST_PUSH;
                    end
                end else
`endif
                if (key_pressed) begin
                    if (is_digit(key_value)) begin
`ifdef KPFIFO_AUTOPUSH_EN
                        if (!lock_q) begin
                            ecmd      = ECMD_DIGIT;
                            ap_pend_d = (digit_cnt == CNT_W'(NIB - 1));
                        end
`else
                        ecmd = ECMD_DIGIT;
`endif
                    end else begin
                        case (key_value)
                            KEY_PUSH: begin
                                if (digit_cnt == '0) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_PUSH_NODIG;
                                end else if (fifo_full) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_PUSH_FULL;
                                end else begin
                                    state_d = ST_PUSH;
                                end
                            end
                            KEY_POP: begin
                                if (fifo_empty) begin
                                    err_d      = 1'b1;
                                    err_code_d = ERR_POP_EMPTY;
                                end else begin
                                    state_d = ST_POP_RD;
                                end
                            end
                            KEY_CLR: begin
                                ecmd = ECMD_CLR;
`ifdef KPFIFO_AUTOPUSH_EN
                                lock_d = 1'b0;
`endif
                            end
                            KEY_FLUSH: if (!fifo_empty) state_d = ST_FL_RD;
                            KEY_BS:    ecmd = ECMD_BS;
                            default:   ;
                        endcase
                    end
                end
            end
            ST_PUSH: begin
                fifo_wr_en = 1'b1;
                ecmd       = ECMD_CLR;
                state_d    = ST_IDLE;
`ifdef KPFIFO_AUTOPUSH_EN
                lock_d     = 1'b0;
`endif
            end
            ST_POP_RD: begin
                fifo_rd_en = 1'b1;
                state_d    = ST_POP_CAP;
            end
            ST_POP_CAP: begin
                pop_valid  = 1'b1;
                last_pop_d = fifo_rd_data;
                state_d    = ST_IDLE;
            end
            ST_FL_RD: begin
                fifo_rd_en = 1'b1;
                state_d    = ST_FL_CAP;
            end
            ST_FL_CAP: begin
                // fifo_empty here already reflects the read just completed
                pop_valid  = 1'b1;
                last_pop_d = fifo_rd_data;
                state_d    = fifo_empty ? ST_IDLE : ST_FL_RD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            last_pop_q <= '0;
`ifdef KPFIFO_AUTOPUSH_EN
            ap_pend_q  <= 1'b0;
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            last_pop_q <= last_pop_d;
`ifdef KPFIFO_AUTOPUSH_EN
            ap_pend_q  <= ap_pend_d;
            lock_q     <= lock_d;
`endif
        end
    end

    // popped word is shown in the same cycle as its pop_valid pulse
    assign last_pop     = pop_valid ? fifo_rd_data : last_pop_q;
    assign fifo_wr_data = entry;
    assign busy         = (state_q != ST_IDLE);
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_keypad_fifo_ctrl.sv
// Scoreboard bench for keypad_fifo_ctrl with a depth-4 behavioural FIFO.
module tb_keypad_fifo_ctrl;
    import kpfifo_pkg::*;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_POP = 2;
    localparam int EV_ERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_value;
    logic       key_pressed;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rd_data = '0;
    logic       fifo_wr_en, fifo_rd_en;
    logic [7:0] fifo_wr_data, entry, last_pop;
    logic [1:0] digit_cnt;
    logic       pop_valid, busy, err;
    logic [1:0] err_code;

    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];

    always #5 clk = ~clk;

    keypad_fifo_ctrl #(.DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_value    (key_value),
        .key_pressed  (key_pressed),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .entry        (entry),
        .digit_cnt    (digit_cnt),
        .last_pop     (last_pop),
        .pop_valid    (pop_valid),
        .busy         (busy),
        .err          (err),
        .err_code     (err_code)
    );

    // environment FIFO: read data registered on the rd_en edge, flags from count
    logic [7:0]  mem [4];
    int unsigned wp = 0, rp = 0, fcnt = 0;
    always @(posedge clk) begin
        if (fifo_wr_en && fcnt < 4) begin
            mem[wp[1:0]] <= fifo_wr_data;
            wp           <= (wp + 1) % 4;
            fcnt         <= fcnt + 1;
        end
        if (fifo_rd_en && fcnt > 0) begin
            fifo_rd_data <= mem[rp[1:0]];
            rp           <= (rp + 1) % 4;
            fcnt         <= fcnt - 1;
        end
    end
    assign fifo_full  = (fcnt == 4);
    assign fifo_empty = (fcnt == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic sb_expect(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_match(input int kind, input logic [7:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0d/%0h required=none", kind, data);
        end else begin
            e = sb.pop_front();
            chk("sb_event", {kind[15:0], 8'h00, data}, {e.kind[15:0], 8'h00, e.data});
        end
    endtask

    // monitor: every DUT strobe must match the next expected event
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("wr_rd_exclusive", {31'd0, fifo_wr_en & fifo_rd_en}, 32'd0);
                if (fifo_wr_en) sb_match(EV_WR, fifo_wr_data);
                if (fifo_rd_en) sb_match(EV_RD, 8'h00);
                if (pop_valid)  sb_match(EV_POP, last_pop);
                if (err)        sb_match(EV_ERR, {6'd0, err_code});
            end
        end
    end

    task automatic press(input logic [3:0] k);
        key_value   = k;
        key_pressed = 1'b1;
        @(negedge clk);
        key_pressed = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        sb_expect(EV_WR, w);
        press(w[7:4]);
        press(w[3:0]);
`ifndef KPFIFO_AUTOPUSH_EN
        press(KEY_PUSH);
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic flush_run(input bit inject, output int n);
        n = 0;
        press(KEY_FLUSH);
        while (busy && n < 40) begin
            n++;
            key_value   = 4'h7;
            key_pressed = inject && (n == 2);
            @(negedge clk);
        end
        key_pressed = 1'b0;
    endtask

    logic [7:0] w0;
    int         n;

    initial begin
        reset       = 1'b1;
        key_value   = '0;
        key_pressed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_entry", {24'd0, entry}, 32'd0);
        chk("rst_cnt", {30'd0, digit_cnt}, 32'd0);
        chk("rst_last_pop", {24'd0, last_pop}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_strobes", {27'd0, fifo_wr_en, fifo_rd_en, pop_valid, busy, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

`ifdef KPFIFO_AUTOPUSH_EN
        w0 = 8'h98;
        press(4'h9);
        chk("ap_entry1", {24'd0, entry}, 32'h09);
        sb_expect(EV_WR, 8'h98);
        press(4'h8);
        chk("ap_entry2", {24'd0, entry}, 32'h98);
        chk("ap_cnt2", {30'd0, digit_cnt}, 32'd2);
        @(negedge clk);
        chk("ap_wr_strobe", {31'd0, fifo_wr_en}, 32'd1);
        @(negedge clk);
        chk("ap_entry_cleared", {22'd0, digit_cnt, entry}, 32'd0);
        press(4'h4);
        chk("bs_pre", {22'd0, digit_cnt, entry}, {22'd0, 2'd1, 8'h04});
        press(KEY_BS);
        chk("bs_one", {22'd0, digit_cnt, entry}, 32'd0);
        press(KEY_BS);
        chk("bs_saturate", {22'd0, digit_cnt, entry}, 32'd0);
`else
        w0 = 8'h12;
        press(4'h1);
        chk("entry_1", {24'd0, entry}, 32'h01);
        press(4'h2);
        chk("entry_12", {22'd0, digit_cnt, entry}, {22'd0, 2'd2, 8'h12});
        sb_expect(EV_WR, 8'h12);
        press(KEY_PUSH);
        chk("push_strobe", {23'd0, fifo_wr_en, fifo_wr_data}, {23'd0, 1'b1, 8'h12});
        @(negedge clk);
        chk("push_once", {31'd0, fifo_wr_en}, 32'd0);
        chk("push_cleared", {22'd0, digit_cnt, entry}, 32'd0);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        chk("overflow_shift", {22'd0, digit_cnt, entry}, {22'd0, 2'd2, 8'h23});
        press(KEY_BS);
        chk("backspace", {22'd0, digit_cnt, entry}, {22'd0, 2'd1, 8'h02});
        press(KEY_CLR);
        chk("clear", {22'd0, digit_cnt, entry}, 32'd0);
        press(KEY_BS);
        chk("bs_saturate", {22'd0, digit_cnt, entry}, 32'd0);
`endif

        sb_expect(EV_RD, 8'h00);
        sb_expect(EV_POP, w0);
        press(KEY_POP);
        chk("pop_rd_e1", {30'd0, fifo_rd_en, busy}, 32'd3);
        @(negedge clk);
        chk("pop_valid_e2", {23'd0, pop_valid, last_pop}, {23'd0, 1'b1, w0});
        @(negedge clk);
        chk("pop_idle_e3", {23'd0, busy, last_pop}, {23'd0, 1'b0, w0});

        sb_expect(EV_ERR, 8'h02);
        press(KEY_POP);
        chk("pop_empty_err", {31'd0, err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("err_code_hold", {29'd0, err, err_code}, 32'd2);

        sb_expect(EV_ERR, 8'h03);
        press(KEY_PUSH);
        chk("push_nodig_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b11});
        @(negedge clk);

        for (int i = 1; i <= 4; i++) begin
            sb_expect(EV_WR, 8'(i));
            press(4'(i));
            press(KEY_PUSH);
            repeat (2) @(negedge clk);
        end

`ifdef KPFIFO_AUTOPUSH_EN
        sb_expect(EV_ERR, 8'h01);
        press(4'h4);
        press(4'h5);
        @(negedge clk);
        chk("full_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b01});
        @(negedge clk);
        press(4'h6);
        chk("locked_entry", {22'd0, digit_cnt, entry}, {22'd0, 2'd2, 8'h45});
`else
        sb_expect(EV_ERR, 8'h01);
        press(4'h4);
        press(4'h5);
        press(KEY_PUSH);
        chk("full_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b01});
        @(negedge clk);
        chk("full_entry_kept", {22'd0, digit_cnt, entry}, {22'd0, 2'd2, 8'h45});
`endif
        press(KEY_CLR);
        chk("clear_after_full", {22'd0, digit_cnt, entry}, 32'd0);

        for (int i = 1; i <= 4; i++) begin
            sb_expect(EV_RD, 8'h00);
            sb_expect(EV_POP, 8'(i));
        end
        flush_run(1'b0, n);
        chk("flush4_busy", n, 32'd8);
        chk("flush4_last", {24'd0, last_pop}, 32'h04);

        press(KEY_FLUSH);
        chk("flush_empty_idle", {30'd0, busy, err}, 32'd0);
        repeat (2) @(negedge clk);

        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        for (int i = 1; i <= 3; i++) begin
            sb_expect(EV_RD, 8'h00);
            sb_expect(EV_POP, 8'(i * 8'h11));
        end
        flush_run(1'b1, n);
        chk("flush3_busy", n, 32'd6);
        chk("flush3_last", {24'd0, last_pop}, 32'h33);
        chk("flush3_key_dropped", {22'd0, digit_cnt, entry}, 32'd0);

        push_word(8'h56);
        sb_expect(EV_RD, 8'h00);
        press(KEY_FLUSH);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_abort", {28'd0, fifo_wr_en, fifo_rd_en, pop_valid, busy}, 32'd0);
        chk("reset_err_code", {30'd0, err_code}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
